// File: rtl/rle_prefetch_fifo.sv
// rle_prefetch_fifo: keeps a small FIFO of flash words topped up for the RLE
// decoder. A fetch FSM issues start/continue read pulses to the SPI flash
// controller one word at a time. The decoder reads the FIFO head from a
// registered output. A decoder stop flushes the buffer and restarts the
// flash stream from address 0.
module rle_prefetch_fifo #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  output logic                    spi_start_read,
  output logic                    spi_continue_read,
  output logic                    spi_stop_read,
  input  logic                    spi_busy,
  input  logic [DATA_WIDTH-1:0]   spi_data,
  input  logic                    dec_read_next,
  input  logic                    dec_stop,
  output logic                    dec_data_ready,
  output logic [DATA_WIDTH-1:0]   dec_data,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  // S_REQ is the cycle the request pulse is on the wire. spi_busy is not
  // trusted until the controller has had that cycle to raise it, so WAIT
  // starts one cycle after the pulse.
  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_STOP
  } state_e;

  state_e                 state_q, state_d;
  logic                   streaming_q, streaming_d;
  logic                   stop_pend_q, stop_pend_d;
  logic                   start_q, start_d;
  logic                   cont_q, cont_d;
  logic                   stop_q, stop_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   ready_q, ready_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   push;
  logic                   pop;

  logic [DATA_WIDTH-1:0]  mem [DEPTH];

  // Next-state logic: fetch FSM, FIFO pointers/count and the next head word.
  always_comb begin
    // NOTE: every _d starts from its _q (pulses from 0) before any branch, so no path can infer a latch.
    state_d     = state_q;
    streaming_d = streaming_q;
    stop_pend_d = stop_pend_q;
    start_d     = 1'b0;
    cont_d      = 1'b0;
    stop_d      = 1'b0;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    push        = 1'b0;
    pop         = 1'b0;

    if (dec_stop) begin
      // Flush wins over any pop or capture on this edge; the word still
      // in flight is dropped because WAIT is abandoned.
      state_d     = S_STOP;
      streaming_d = 1'b0;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      if (stop_q) begin
        // Stop already on the wire; just extend STOP.
        stop_pend_d = 1'b0;
      end else if (start_q || cont_q) begin
        // A request pulse is high right now; pulsing stop next cycle would
        // put two pulses back to back, so defer it by one cycle.
        stop_pend_d = 1'b1;
      end else begin
        stop_d      = 1'b1;
        stop_pend_d = 1'b0;
      end
    end else begin
      pop = dec_read_next && (count_q != '0);

      case (state_q)
        S_IDLE: begin
          if (enable && (count_q < DEPTH_C)) begin
            start_d     = !streaming_q;
            cont_d      = streaming_q;
            streaming_d = 1'b1;
            state_d     = S_REQ;
          end
        end
        S_REQ: begin
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (!spi_busy) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_STOP: begin
          if (stop_pend_q) begin
            stop_d      = 1'b1;
            stop_pend_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end

    // Head word as seen after this edge. If every stored word is consumed
    // (or none was stored) the new head is the word being captured.
    ready_d = (count_d != '0);
    if (count_d == '0) begin
      data_d = '0;
    end else if ((count_q == '0) || (pop && (count_q == CNT_ONE))) begin
      data_d = spi_data;
    end else begin
      data_d = mem[rd_ptr_d];
    end
  end

  // State, pointer and registered-output flops with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples the same pre-edge values.
    if (rst) begin
      state_q     <= S_IDLE;
      streaming_q <= 1'b0;
      stop_pend_q <= 1'b0;
      start_q     <= 1'b0;
      cont_q      <= 1'b0;
      stop_q      <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      ready_q     <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      streaming_q <= streaming_d;
      stop_pend_q <= stop_pend_d;
      start_q     <= start_d;
      cont_q      <= cont_d;
      stop_q      <= stop_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      ready_q     <= ready_d;
      data_q      <= data_d;
    end
  end

  // Word storage, written at the tail on each capture.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is left out of reset; a slot is only read after it has been written, and dec_data is held at 0 while empty.
    if (push) mem[wr_ptr_q] <= spi_data;
  end

  assign spi_start_read    = start_q;
  assign spi_continue_read = cont_q;
  assign spi_stop_read     = stop_q;
  assign dec_data_ready    = ready_q;
  assign dec_data          = data_q;
  assign level             = count_q;

endmodule
